// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the IF/ID buffer entry type.
package riscv_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two >= 2.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    T [DEPTH-1:0]  mem;
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem req/gnt/rvalid, response buffer and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o
);

    import riscv_pkg::*;

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT   = (AW+2)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [31:0]   pc_q, rsp_pc;
    logic [AW:0]   discard_q, out_cnt, buf_cnt;
    logic [AW+1:0] inflight;
    logic          aq_full, aq_empty, buf_full, buf_empty;
    logic          fire, rsp_ok, rsp_live, rsp_drop, bypass, buf_push, buf_pop;
    fetch_entry_t  buf_head, rsp_entry;
    logic          unused_ok;

    // Every outstanding request owns a buffer slot in advance, so the buffer never overflows.
    assign inflight    = {1'b0, out_cnt} + {1'b0, buf_cnt};
    assign imem_req_o  = !rst && !redirect_i && !aq_full && (inflight < LIMIT);
    assign imem_addr_o = pc_q;
    assign fire        = imem_req_o && imem_gnt_i;

    assign rsp_ok    = imem_rvalid_i && !aq_empty;
    assign rsp_live  = rsp_ok && (discard_q == '0);
    assign rsp_drop  = rsp_ok && (discard_q != '0);
    assign bypass    = rsp_live && buf_empty && !stall_i && !redirect_i;
    assign buf_push  = rsp_live && !bypass;
    assign buf_pop   = !redirect_i && !stall_i && !buf_empty;
    assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata_i};
    assign unused_ok = buf_full;

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (fire),
        .din   (pc_q),
        .pop   (rsp_ok),
        .dout  (rsp_pc),
        .count (out_cnt),
        .full  (aq_full),
        .empty (aq_empty)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_i),
        .push  (buf_push),
        .din   (rsp_entry),
        .pop   (buf_pop),
        .dout  (buf_head),
        .count (buf_cnt),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            discard_q     <= '0;
            pc_o          <= '0;
            instr_o       <= NOP_INSN;
            instr_valid_o <= 1'b0;
        end else begin
            // Everything still in flight at a redirect belongs to the old stream.
            if (redirect_i) begin
                pc_q      <= {redirect_pc_i[31:2], 2'b00};
                discard_q <= out_cnt - (rsp_ok ? CNT_ONE : '0);
            end else begin
                if (fire)     pc_q      <= pc_q + 32'd4;
                if (rsp_drop) discard_q <= discard_q - CNT_ONE;
            end

            if (redirect_i) begin
                pc_o          <= '0;
                instr_o       <= NOP_INSN;
                instr_valid_o <= 1'b0;
            end else if (!stall_i) begin
                if (!buf_empty) begin
                    pc_o          <= buf_head.pc;
                    instr_o       <= buf_head.instr;
                    instr_valid_o <= 1'b1;
                end else if (bypass) begin
                    pc_o          <= rsp_pc;
                    instr_o       <= imem_rdata_i;
                    instr_valid_o <= 1'b1;
                end else begin
                    pc_o          <= '0;
                    instr_o       <= NOP_INSN;
                    instr_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus, queued expectations, separate monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, redirect_i = 1'b0, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
    logic        imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, pc_o, instr_o;

    logic        w_req, w_valid;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_addr, w_pc, w_instr;

    int n_cmp = 0, n_bad = 0;

    logic [31:0] pend[$];
    logic [31:0] addr_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_gnt_i(1'b1), .imem_rvalid_i(w_rvalid), .imem_rdata_i(32'h00A0_0093),
        .pc_o(w_pc), .instr_o(w_instr), .instr_valid_o(w_valid)
    );

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], 16'h0513};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_out(input logic [31:0] pc);
        exp_q.push_back({pc, rd_of(pc)});
    endtask

    // One cycle of stimulus; the memory answers each grant one cycle later unless rsp is low.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit g, input bit rsp);
        @(negedge clk);
        if (rsp && pend.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = rd_of(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        stall_i = st; redirect_i = rd; redirect_pc_i = rpc; imem_gnt_i = g;
        #1;
        if (imem_req_o && imem_gnt_i) pend.push_back(imem_addr_o);
    endtask

    task automatic run(input int n, input bit g);
        repeat (n) step(1'b0, 1'b0, 32'h0, g, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        pend.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: IF/ID outputs not held by a stall are popped against exp_q, grants against addr_q.
    always begin
        bit          held;
        logic [63:0] e;
        @(posedge clk);
        held = stall_i && !redirect_i;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (instr_valid_o && !held) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_extra: got pc %h with nothing expected", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", pc_o, e[63:32]);
                    chk("out_instr", instr_o, e[31:0]);
                end
            end
            if (imem_req_o && imem_gnt_i) begin
                if (addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL addr_extra: got %h with nothing expected", imem_addr_o);
                end else begin
                    chk("imem_addr", imem_addr_o, addr_q.pop_front());
                end
            end
        end
    end

    // Wrap instance: always granted, answered one cycle after each grant.
    int          w_n = 0;
    bit          w_pend = 1'b0, w_seen = 1'b0;
    logic [31:0] w_exp[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    always @(negedge clk) begin
        #1;
        if (rst) begin
            w_pend   = 1'b0;
            w_rvalid = 1'b0;
        end else begin
            w_rvalid = w_pend;
            if (w_valid && !w_seen) begin
                w_seen = 1'b1;
                chk("wrap_first_pc", w_pc, 32'hFFFF_FFF8);
                chk("wrap_first_instr", w_instr, 32'h00A0_0093);
            end
            w_pend = w_req;
            if (w_req && w_n < 3) begin
                chk("wrap_addr", w_addr, w_exp[w_n]);
                w_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);

        // Stream plus a 3-cycle stall while pc 0x8 sits in IF/ID
        for (int a = 0; a <= 32'h20; a += 4) begin
            addr_q.push_back(a);
            exp_out(a);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req", {31'h0, imem_req_o}, 32'h1);
        chk("first_addr", imem_addr_o, 32'h0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("lat_valid_lo", {31'h0, instr_valid_o}, 32'h0);
        step(0, 0, 0, 1, 1);
        chk("lat_valid_hi", {31'h0, instr_valid_o}, 32'h1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        chk("stall_req_drop", {31'h0, imem_req_o}, 32'h0);
        chk("stall_pc", pc_o, 32'h8);
        step(1, 0, 0, 1, 1);
        chk("stall_req_drop2", {31'h0, imem_req_o}, 32'h0);
        step(0, 0, 0, 1, 1);
        chk("stall_pc_held", pc_o, 32'h8);
        chk("stall_instr_held", instr_o, rd_of(32'h8));
        run(4, 1);
        run(5, 0);
        chk("a_exp_drained", exp_q.size(), 0);
        chk("a_addr_drained", addr_q.size(), 0);

        // Redirect with two stale fetches outstanding, then redirect+stall, then gnt low
        do_reset();
        foreach (w_exp[i]) begin end
        addr_q.push_back(32'h0);   addr_q.push_back(32'h4);   addr_q.push_back(32'h8);
        addr_q.push_back(32'hC);   addr_q.push_back(32'h100); addr_q.push_back(32'h104);
        addr_q.push_back(32'h200); addr_q.push_back(32'h204); addr_q.push_back(32'h208);
        addr_q.push_back(32'h20C); addr_q.push_back(32'h210); addr_q.push_back(32'h214);
        exp_out(32'h0);   exp_out(32'h4);   exp_out(32'h100);
        exp_out(32'h200); exp_out(32'h204); exp_out(32'h208);
        exp_out(32'h20C); exp_out(32'h210); exp_out(32'h214);
        run(3, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h103, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("redir_instr", instr_o, 32'h0000_0013);
        chk("redir_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("redir_pc", pc_o, 32'h0);
        chk("redir_req", {31'h0, imem_req_o}, 32'h1);
        chk("redir_addr", imem_addr_o, 32'h100);
        step(0, 0, 0, 1, 1);
        step(1, 1, 32'h200, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("rs_instr", instr_o, 32'h0000_0013);
        chk("rs_valid", {31'h0, instr_valid_o}, 32'h0);
        run(2, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            chk("gl_req", {31'h0, imem_req_o}, 32'h1);
            chk("gl_addr", imem_addr_o, 32'h20C);
            if (i >= 2) begin
                chk("gl_bubble_instr", instr_o, 32'h0000_0013);
                chk("gl_bubble_valid", {31'h0, instr_valid_o}, 32'h0);
            end
        end
        step(0, 0, 0, 1, 1);
        chk("gl_bubble_instr", instr_o, 32'h0000_0013);
        run(2, 1);
        run(5, 0);
        chk("b_exp_drained", exp_q.size(), 0);
        chk("b_addr_drained", addr_q.size(), 0);

        // Reset asserted with a fetch in flight and a live instruction in IF/ID
        addr_q.push_back(32'h218); addr_q.push_back(32'h21C); addr_q.push_back(32'h220);
        exp_out(32'h218);
        run(3, 1);
        #2;
        rst = 1'b1;
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
        pend.delete();
        #1;
        chk("mr_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("mr_instr", instr_o, 32'h0000_0013);
        chk("mr_pc", pc_o, 32'h0);
        chk("mr_req", {31'h0, imem_req_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'h0, imem_req_o}, 32'h1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        @(negedge clk);
        chk("end_exp_empty", exp_q.size(), 0);
        chk("end_addr_empty", addr_q.size(), 0);
        chk("wrap_count", w_n, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
